// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared types and widths for the fetch PC sequencer
package pc_seq_pkg;

    localparam int PC_W    = 32;
    localparam int PC_STEP = 4;
    localparam int CNT_W   = 16;
    localparam int BUB_W   = 4;

    typedef enum logic {
        FETCH = 1'b0,
        FLUSH = 1'b1
    } seqState_e;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [PC_W-1:0] alignPc(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - fetch/redirect bundle between branch unit, imem and sequencer
interface pc_sequencer_if;
    import pc_seq_pkg::*;

    logic             is_branch_taken;
    logic [PC_W-1:0]  branch_pc;
    logic             stall;
    logic             imem_ready;
    logic             imem_req;
    logic [PC_W-1:0]  pc;
    logic             fetch_valid;
    logic             flush;
    logic             misaligned;
    logic [CNT_W-1:0] taken_count;

    modport master (
        input  is_branch_taken, branch_pc, stall, imem_ready,
        output imem_req, pc, fetch_valid, flush, misaligned, taken_count
    );

    modport slave (
        output is_branch_taken, branch_pc, stall, imem_ready,
        input  imem_req, pc, fetch_valid, flush, misaligned, taken_count
    );

endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch PC sequencer with redirect, bubble flush and taken counter
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC     = 32'h0000_0000,
    parameter int              FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             is_branch_taken,
    input  logic [PC_W-1:0]  branch_pc,
    input  logic             stall,
    input  logic             imem_ready,
    output logic             imem_req,
    output logic [PC_W-1:0]  pc,
    output logic             fetch_valid,
    output logic             flush,
    output logic             misaligned,
    output logic [CNT_W-1:0] taken_count
);

    localparam logic [BUB_W-1:0] BUB_LOAD = BUB_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    seqState_e        state;
    logic [BUB_W-1:0] bubbleCnt;

    assign imem_req    = (state == FETCH) & ~stall & ~is_branch_taken;
    assign fetch_valid = imem_req & imem_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            bubbleCnt   <= '0;
            flush       <= 1'b0;
            misaligned  <= 1'b0;
            taken_count <= '0;
        end else if (is_branch_taken) begin
            // A redirect wins over stall, imem backpressure and any flush in progress.
            state      <= FLUSH;
            pc         <= alignPc(branch_pc);
            bubbleCnt  <= BUB_LOAD;
            flush      <= 1'b1;
            misaligned <= |branch_pc[1:0];
            if (taken_count != CNT_MAX) begin
                taken_count <= taken_count + CNT_W'(1);
            end
        end else begin
            flush      <= 1'b0;
            misaligned <= 1'b0;
            case (state)
                FETCH: begin
                    if (fetch_valid) begin
                        pc <= pc + PC_W'(PC_STEP);
                    end
                end
                FLUSH: begin
                    // Bubbles drain even while the pipeline is stalled.
                    if (bubbleCnt == '0) begin
                        state <= FETCH;
                    end else begin
                        bubbleCnt <= bubbleCnt - BUB_W'(1);
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer against a cycle-level reference model
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          FC     = 2;

    localparam int K_PC = 0, K_REQ = 1, K_FV = 2, K_FLUSH = 3, K_MIS = 4, K_CNT = 5;

    typedef struct {
        int          id;
        logic        chk;
        logic [31:0] pc;
        logic        req;
        logic        fv;
        logic        flush;
        logic        mis;
        logic [15:0] cnt;
    } exp_t;

    typedef struct {
        int          id;
        int          kind;
        logic [31:0] val;
    } spot_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pc_sequencer_if bus ();

    pc_sequencer #(
        .RESET_PC     (RST_PC),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .is_branch_taken (bus.is_branch_taken),
        .branch_pc       (bus.branch_pc),
        .stall           (bus.stall),
        .imem_ready      (bus.imem_ready),
        .imem_req        (bus.imem_req),
        .pc              (bus.pc),
        .fetch_valid     (bus.fetch_valid),
        .flush           (bus.flush),
        .misaligned      (bus.misaligned),
        .taken_count     (bus.taken_count)
    );

    always #5 clk = ~clk;

    exp_t  expQ[$];
    spot_t spotQ[$];
    int    passCnt  = 0;
    int    totalCnt = 0;
    int    cyc      = 0;
    int    lastId   = 0;

    // Reference model: fetching resumes at an absolute cycle number after a redirect.
    logic [31:0] mPc;
    int          mResume;
    logic        mFlush;
    logic        mMis;
    logic [15:0] mCnt;

    task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] want);
        totalCnt++;
        if (act === want) passCnt++;
        else $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, id, act, want);
    endtask

    task automatic step(input logic r, input logic br, input logic [31:0] bpc,
                        input logic st, input logic rdy, input logic chk);
        exp_t e;
        logic fetching;
        @(posedge clk);
        #1;
        rst                 = r;
        bus.is_branch_taken = br;
        bus.branch_pc       = bpc;
        bus.stall           = st;
        bus.imem_ready      = rdy;
        fetching = (cyc >= mResume);
        e.id    = cyc;
        e.chk   = chk;
        e.pc    = mPc;
        e.req   = fetching && !st && !br;
        e.fv    = e.req && rdy;
        e.flush = mFlush;
        e.mis   = mMis;
        e.cnt   = mCnt;
        expQ.push_back(e);
        if (r) begin
            mPc = RST_PC; mResume = cyc + 1; mFlush = 0; mMis = 0; mCnt = 0;
        end else if (br) begin
            mPc     = {bpc[31:2], 2'b00};
            mResume = cyc + FC + 1;
            mFlush  = 1;
            mMis    = (bpc[1:0] != 2'b00);
            if (mCnt != 16'hFFFF) mCnt = mCnt + 16'd1;
        end else begin
            mFlush = 0; mMis = 0;
            if (e.fv) mPc = mPc + 32'd4;
        end
        lastId = cyc;
        cyc++;
    endtask

    task automatic spot(input int kind, input logic [31:0] val);
        spot_t s;
        s.id = lastId; s.kind = kind; s.val = val;
        spotQ.push_back(s);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic redirect(input logic [31:0] tgt, input logic st);
        step(1'b0, 1'b1, tgt, st, 1'b1, 1'b1);
    endtask

    // Monitor: pops one expectation per cycle, away from the active edge.
    initial begin
        exp_t  e;
        spot_t s;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                if (e.chk) begin
                    check("pc",          e.id, bus.pc,                  e.pc);
                    check("imem_req",    e.id, {31'd0, bus.imem_req},    {31'd0, e.req});
                    check("fetch_valid", e.id, {31'd0, bus.fetch_valid}, {31'd0, e.fv});
                    check("flush",       e.id, {31'd0, bus.flush},       {31'd0, e.flush});
                    check("misaligned",  e.id, {31'd0, bus.misaligned},  {31'd0, e.mis});
                    check("taken_count", e.id, {16'd0, bus.taken_count}, {16'd0, e.cnt});
                end
                while (spotQ.size() > 0 && spotQ[0].id == e.id) begin
                    s = spotQ.pop_front();
                    case (s.kind)
                        K_PC:    check("spot_pc",    s.id, bus.pc,                  s.val);
                        K_REQ:   check("spot_req",   s.id, {31'd0, bus.imem_req},    s.val);
                        K_FV:    check("spot_fv",    s.id, {31'd0, bus.fetch_valid}, s.val);
                        K_FLUSH: check("spot_flush", s.id, {31'd0, bus.flush},       s.val);
                        K_MIS:   check("spot_mis",   s.id, {31'd0, bus.misaligned},  s.val);
                        default: check("spot_cnt",   s.id, {16'd0, bus.taken_count}, s.val);
                    endcase
                end
            end
        end
    end

    initial begin
        bus.is_branch_taken = 1'b0;
        bus.branch_pc       = 32'h0;
        bus.stall           = 1'b0;
        bus.imem_ready      = 1'b1;
        mPc = RST_PC; mResume = 0; mFlush = 0; mMis = 0; mCnt = 0;

        // Reset then sequential fetch from RESET_PC.
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        spot(K_FLUSH, 0); spot(K_MIS, 0); spot(K_CNT, 0); spot(K_PC, RST_PC);
        idle(1); spot(K_PC, 32'h100); spot(K_FV, 1);
        idle(1); spot(K_PC, 32'h104); spot(K_FV, 1);
        idle(1); spot(K_PC, 32'h108); spot(K_FV, 1);

        // Redirect to 0x2000 taken in the cycle pc is 0x108.
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        idle(2);
        redirect(32'h2000, 1'b0); spot(K_PC, 32'h108); spot(K_REQ, 0);
        idle(1); spot(K_FLUSH, 1); spot(K_REQ, 0); spot(K_PC, 32'h2000); spot(K_CNT, 1);
        idle(1); spot(K_FLUSH, 0); spot(K_REQ, 0);
        idle(1); spot(K_REQ, 1); spot(K_PC, 32'h2000);

        // Stall at 0x40, then redirect while stalled.
        redirect(32'h40, 1'b0);
        idle(2);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1); spot(K_PC, 32'h40); spot(K_REQ, 0);
        end
        step(1'b0, 1'b1, 32'h80, 1'b1, 1'b1, 1'b1); spot(K_PC, 32'h40);
        idle(1); spot(K_FLUSH, 1); spot(K_PC, 32'h80);
        idle(2);

        // Misaligned target.
        redirect(32'h3002, 1'b0);
        idle(1); spot(K_PC, 32'h3000); spot(K_MIS, 1);
        idle(1); spot(K_MIS, 0);

        // Wrap at the top of the address space, with imem backpressure first.
        redirect(32'hFFFF_FFFC, 1'b0);
        idle(2);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1); spot(K_PC, 32'hFFFF_FFFC); spot(K_FV, 0);
        end
        idle(1); spot(K_FV, 1);
        idle(1); spot(K_PC, 32'h0);

        // Back-to-back redirects, then reset mid-flush.
        redirect(32'h500, 1'b0);
        redirect(32'h600, 1'b0); spot(K_PC, 32'h500); spot(K_FLUSH, 1);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1); spot(K_PC, 32'h600); spot(K_FLUSH, 1);
        idle(1); spot(K_PC, RST_PC); spot(K_CNT, 0); spot(K_FLUSH, 0); spot(K_REQ, 1);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0, $urandom,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, 1'b1);
        end
        idle(1);

        @(negedge clk);
        @(negedge clk);
        totalCnt++;
        if (expQ.size() == 0) passCnt++;
        else $display("FAIL drain: got %0d pending expectations, expected 0", expQ.size());
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
